// File: rtl/timer_mc_pkg.sv
// timer_mc_pkg: register map, channel layout, CH_CTRL bit positions and shared types for timer_mc
package timer_mc_pkg;
  localparam logic [9:0] CTRL_OFF        = 10'h000;
  localparam logic [9:0] PRESCALE_OFF    = 10'h004;
  localparam logic [9:0] MTIME_LO_OFF    = 10'h008;
  localparam logic [9:0] MTIME_HI_OFF    = 10'h00C;
  localparam logic [9:0] INTR_STATE_OFF  = 10'h010;
  localparam logic [9:0] INTR_ENABLE_OFF = 10'h014;
  localparam logic [9:0] CH_BASE         = 10'h100;
  localparam logic [9:0] CH_STRIDE       = 10'h010;
  localparam logic [3:0] CMP_LO_OFF      = 4'h0;
  localparam logic [3:0] CMP_HI_OFF      = 4'h4;
  localparam logic [3:0] CH_CTRL_OFF     = 4'h8;
  localparam logic [3:0] RELOAD_OFF      = 4'hC;
  localparam int CH_CTRL_EN_BIT  = 0;
  localparam int CH_CTRL_PER_BIT = 1;
  typedef struct packed {
    logic periodic;
    logic enable;
  } ch_cfg_t;
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] wdata, input logic [3:0] be);
    return (old_v & ~be_mask(be)) | (wdata & be_mask(be));
  endfunction
endpackage

// File: rtl/timer_mc_channel.sv
// timer_mc_channel: one compare channel holding a 64-bit compare value, reload value and enable/periodic control
module timer_mc_channel import timer_mc_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] mtime_i,
  input  logic        wr_i,
  input  logic [3:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        match_o,
  output logic [31:0] rdata_o
);
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] cfg_rd;
  ch_cfg_t cfg_q, cfg_d;

  assign match_o = cfg_q.enable && mtime_i >= cmp_q;

  // a match advances the compare or disarms the channel; a bus write to a register overrides that register
  always_comb begin
    cmp_d = match_o && cfg_q.periodic ? cmp_q + {32'h0, reload_q} : cmp_q;
    reload_d = reload_q;
    cfg_d = cfg_q;
    if (match_o && !cfg_q.periodic) cfg_d.enable = 1'b0;
    if (wr_i && off_i == CMP_LO_OFF) cmp_d[31:0] = be_merge(cmp_q[31:0], wdata_i, be_i);
    if (wr_i && off_i == CMP_HI_OFF) cmp_d[63:32] = be_merge(cmp_q[63:32], wdata_i, be_i);
    if (wr_i && off_i == RELOAD_OFF) reload_d = be_merge(reload_q, wdata_i, be_i);
    if (wr_i && off_i == CH_CTRL_OFF && be_i[0]) begin
      cfg_d.enable = wdata_i[CH_CTRL_EN_BIT];
      cfg_d.periodic = wdata_i[CH_CTRL_PER_BIT];
    end
    cfg_rd = '0;
    cfg_rd[CH_CTRL_EN_BIT] = cfg_q.enable;
    cfg_rd[CH_CTRL_PER_BIT] = cfg_q.periodic;
    rdata_o = off_i == CMP_LO_OFF ? cmp_q[31:0] :
              off_i == CMP_HI_OFF ? cmp_q[63:32] :
              off_i == CH_CTRL_OFF ? cfg_rd : reload_q;
  end

  // channel state; the compare value comes out of reset as all-ones so nothing matches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q <= '1;
      reload_q <= '0;
      cfg_q <= '0;
    end else begin
      cmp_q <= cmp_d;
      reload_q <= reload_d;
      cfg_q <= cfg_d;
    end
  end
endmodule

// File: rtl/timer_mc.sv
// timer_mc: multi-channel 64-bit compare timer with prescaler and register bus; TIMER_MC_SHADOW_EN adds an MTIME_HI read shadow
module timer_mc import timer_mc_pkg::*; #(
  parameter int NumChannels   = 4,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int PrescaleWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic                    timer_we_i,
  input  logic [DataWidth/8-1:0]  timer_be_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic [NumChannels-1:0]  timer_intr_o,
  output logic                    timer_intr_any_o
);
  logic [9:0] a, rel;
  logic [2:0] ch_idx;
  logic glb_sel, ch_sel, hit, wr, rd, tick, unused_addr;
  logic [31:0] m, glb_rd, ch_rd, mtime_hi_rd;
  logic [31:0] ch_rdata [NumChannels];
  logic [NumChannels-1:0] match, w1c;
  logic ctrl_q, ctrl_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d, presc_cnt_q, presc_cnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [NumChannels-1:0] intr_state_q, intr_state_d, intr_enable_q, intr_enable_d;
  logic rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  assign a = timer_addr_i[9:0];
  assign rel = a - CH_BASE;
  assign ch_idx = rel[6:4];
  assign ch_sel = a >= CH_BASE && rel < 10'(NumChannels) * CH_STRIDE && rel[1:0] == 2'b00;
  assign glb_sel = a inside {CTRL_OFF, PRESCALE_OFF, MTIME_LO_OFF, MTIME_HI_OFF, INTR_STATE_OFF, INTR_ENABLE_OFF};
  assign hit = glb_sel || ch_sel;
  assign wr = timer_req_i && timer_we_i && hit;
  assign rd = timer_req_i && !timer_we_i && hit;
  assign m = be_mask(timer_be_i);
  assign unused_addr = ^timer_addr_i;
  assign timer_intr_o = intr_state_q & intr_enable_q;
  assign timer_intr_any_o = |timer_intr_o;
  assign timer_rvalid_o = rvalid_q;
  assign timer_rdata_o = rdata_q;
  assign timer_err_o = err_q;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    timer_mc_channel u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .mtime_i (mtime_q),
      .wr_i    (wr && ch_sel && ch_idx == 3'(c)),
      .off_i   (rel[3:0]),
      .wdata_i (timer_wdata_i),
      .be_i    (timer_be_i),
      .match_o (match[c]),
      .rdata_o (ch_rdata[c])
    );
  end

`ifdef TIMER_MC_SHADOW_EN
  logic [31:0] shadow_q, shadow_d;
  assign shadow_d = rd && a == MTIME_LO_OFF ? mtime_q[63:32] : shadow_q;
  assign mtime_hi_rd = shadow_q;
  // upper mtime half captured on each MTIME_LO read for a consistent 64-bit snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) shadow_q <= '0;
    else shadow_q <= shadow_d;
  end
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  // read data of the addressed channel
  always_comb begin
    ch_rd = '0;
    for (int i = 0; i < NumChannels; i++) if (ch_idx == 3'(i)) ch_rd = ch_rdata[i];
  end

  // register updates, prescaler/mtime advance and the registered bus response
  always_comb begin
    ctrl_d = wr && a == CTRL_OFF && timer_be_i[0] ? timer_wdata_i[0] : ctrl_q;
    prescale_d = wr && a == PRESCALE_OFF ? PrescaleWidth'(be_merge(32'(prescale_q), timer_wdata_i, timer_be_i)) : prescale_q;
    tick = ctrl_q && presc_cnt_q >= prescale_q;
    presc_cnt_d = !ctrl_q ? presc_cnt_q : tick ? '0 : presc_cnt_q + PrescaleWidth'(1);
    mtime_d = wr && a == MTIME_LO_OFF ? {mtime_q[63:32], be_merge(mtime_q[31:0], timer_wdata_i, timer_be_i)} :
              wr && a == MTIME_HI_OFF ? {be_merge(mtime_q[63:32], timer_wdata_i, timer_be_i), mtime_q[31:0]} :
              mtime_q + 64'(tick);
    w1c = wr && a == INTR_STATE_OFF ? NumChannels'(timer_wdata_i & m) : '0;
    intr_state_d = (intr_state_q & ~w1c) | match;
    intr_enable_d = wr && a == INTR_ENABLE_OFF ? NumChannels'(be_merge(32'(intr_enable_q), timer_wdata_i, timer_be_i)) : intr_enable_q;
    glb_rd = a == CTRL_OFF ? {31'h0, ctrl_q} :
             a == PRESCALE_OFF ? 32'(prescale_q) :
             a == MTIME_LO_OFF ? mtime_q[31:0] :
             a == MTIME_HI_OFF ? mtime_hi_rd :
             a == INTR_STATE_OFF ? 32'(intr_state_q) : 32'(intr_enable_q);
    rvalid_d = timer_req_i;
    err_d = timer_req_i && !hit;
    rdata_d = rd ? (glb_sel ? glb_rd : ch_rd) : '0;
  end

  // global state and bus response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= 1'b0;
      prescale_q <= '0;
      presc_cnt_q <= '0;
      mtime_q <= '0;
      intr_state_q <= '0;
      intr_enable_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      prescale_q <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      mtime_q <= mtime_d;
      intr_state_q <= intr_state_d;
      intr_enable_q <= intr_enable_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
